song_timer: RTL and testbench

Parametrised song-position timer for the note-playback path. Divides the system clock into ticks and advances a position counter from 0 to a configured maximum. Supports start, pause/resume, clear, seek (load), wrap or stop-at-end, and an optional compare-match pulse. Feeds the note scheduler and the display; supersedes the fixed 29-bit microsecond counter pair.

---
 rtl/song_timer_if.sv | 33 +++
 rtl/song_timer.sv | 124 ++++++++++++
 tb/tb_song_timer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/song_timer_if.sv
// song_timer control/status bundle.
// master drives commands, slave is the timer.
interface song_timer_if #(
  parameter int CNT_W = 29
);
  logic             start;
  logic             pause;
  logic             clear;
  logic             load;
  logic [CNT_W-1:0] load_value;
  logic             wrap_mode;
  logic [CNT_W-1:0] cmp_value;
  logic [CNT_W-1:0] count;
  logic             tick;
  logic             running;
  logic             done;
  logic             wrapped;
  logic             cmp_hit;

  modport master (
    output start, pause, clear, load,
    output load_value, wrap_mode, cmp_value,
    input  count, tick, running, done,
    input  wrapped, cmp_hit
  );

  modport slave (
    input  start, pause, clear, load,
    input  load_value, wrap_mode, cmp_value,
    output count, tick, running, done,
    output wrapped, cmp_hit
  );
endinterface

// File: rtl/song_timer.sv
// Song-position timer: prescaled tick, run/pause/seek/wrap.
// Optional compare-match pulse with SONG_TIMER_CMP_EN.
module song_timer #(
  parameter int TICK_DIV  = 50,
  parameter int CNT_W     = 29,
  parameter int MAX_COUNT = 300000000
) (
  input  logic         clk,
  input  logic         reset,
  song_timer_if.slave  bus
);

  localparam int PRE_W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MAX_C =
    CNT_W'(MAX_COUNT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             wrapped_q, wrapped_d;

  // Next state: clear > load > pause > start,
  // prescaler advances only while running.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    tick_d    = 1'b0;
    wrapped_d = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      pre_d   = '0;
    end else if (bus.load) begin
      cnt_d = (bus.load_value > MAX_C) ?
              MAX_C : bus.load_value;
      pre_d = '0;
      if (state_q == DONE)
        state_d = PAUSED;
    end else if (bus.pause) begin
      if (state_q == RUN)
        state_d = PAUSED;
    end else begin
      if (bus.start && state_q == IDLE) begin
        state_d = RUN;
        pre_d   = '0;
      end else if (bus.start &&
                   state_q == PAUSED) begin
        state_d = RUN;
      end
      if (state_q == RUN) begin
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (cnt_q != MAX_C) begin
            cnt_d  = cnt_q + CNT_W'(1);
            tick_d = 1'b1;
          end else if (bus.wrap_mode) begin
            cnt_d     = '0;
            tick_d    = 1'b1;
            wrapped_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
    end
  end

  // Core state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      tick_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      tick_q    <= tick_d;
      wrapped_q <= wrapped_d;
    end
  end

`ifdef SONG_TIMER_CMP_EN
  logic cmp_q, cmp_d;

  // Match only on a freshly advanced count.
  always_comb begin
    cmp_d = tick_d && (cnt_d == bus.cmp_value);
  end

  // Compare pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cmp_q <= 1'b0;
    else       cmp_q <= cmp_d;
  end

  assign bus.cmp_hit = cmp_q;
`else
  logic unused_cmp;
  assign unused_cmp  = ^bus.cmp_value;
  assign bus.cmp_hit = 1'b0;
`endif

  assign bus.count   = cnt_q;
  assign bus.tick    = tick_q;
  assign bus.wrapped = wrapped_q;
  assign bus.running = (state_q == RUN);
  assign bus.done    = (state_q == DONE);

endmodule

// File: tb/tb_song_timer.sv
// Directed bench for song_timer.
// TICK_DIV=4, MAX_COUNT=5, CNT_W=8.
module tb_song_timer;

`ifdef SONG_TIMER_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  song_timer_if #(.CNT_W(8)) bus ();

  song_timer #(
    .TICK_DIV (4),
    .CNT_W    (8),
    .MAX_COUNT(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_slot(input int exp_cnt,
                           input bit exp_wrap);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("quiet",
          {29'd0, bus.tick, bus.wrapped,
           bus.cmp_hit}, 0);
    end
    cyc();
    chk("tick", bus.tick, 1);
    chk("count", bus.count, exp_cnt);
    chk("wrapped", bus.wrapped, exp_wrap);
    chk("cmp_hit", bus.cmp_hit,
        (CMP && exp_cnt == 3) ? 1 : 0);
  endtask

  initial begin
    n_run          = 0;
    n_fail         = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.pause      = 1'b0;
    bus.clear      = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.wrap_mode  = 1'b0;
    bus.cmp_value  = 8'd3;
    cyc();
    cyc();
    chk("rst_count", bus.count, 0);
    chk("rst_flags",
        {26'd0, bus.tick, bus.running, bus.done,
         bus.wrapped, bus.cmp_hit}, 0);
    reset = 1'b0;
    cyc();

    // run to end, stop mode
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("start_run", bus.running, 1);
    chk("start_cnt", bus.count, 0);
    for (int k = 1; k <= 5; k++)
      tick_slot(k, 1'b0);
    for (int i = 0; i < 3; i++) cyc();
    cyc();
    chk("done", bus.done, 1);
    chk("done_run", bus.running, 0);
    chk("done_cnt", bus.count, 5);
    chk("done_tick", bus.tick, 0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("done_nostart", bus.done, 1);
    bus.load       = 1'b1;
    bus.load_value = 8'd2;
    cyc();
    bus.load = 1'b0;
    chk("dload_done", bus.done, 0);
    chk("dload_run", bus.running, 0);
    chk("dload_cnt", bus.count, 2);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    chk("clr_cnt", bus.count, 0);

    // wrap mode
    bus.wrap_mode = 1'b1;
    bus.start     = 1'b1;
    cyc();
    bus.start = 1'b0;
    for (int k = 1; k <= 5; k++)
      tick_slot(k, 1'b0);
    tick_slot(0, 1'b1);
    tick_slot(1, 1'b0);
    chk("wrap_run", bus.running, 1);

    // pause keeps partial tick
    cyc();
    cyc();
    bus.pause = 1'b1;
    cyc();
    bus.pause = 1'b0;
    chk("paused", bus.running, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("frozen",
          {bus.count, 7'd0, bus.tick}, 32'h100);
    end
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("resume_run", bus.running, 1);
    chk("resume_t0", bus.tick, 0);
    cyc();
    chk("resume_t1", bus.tick, 0);
    cyc();
    chk("resume_tick", bus.tick, 1);
    chk("resume_cnt", bus.count, 2);

    // seek clamps, prescaler restarts
    bus.load       = 1'b1;
    bus.load_value = 8'd200;
    cyc();
    bus.load = 1'b0;
    chk("seek_cnt", bus.count, 5);
    chk("seek_pulse",
        {bus.tick, bus.wrapped, bus.cmp_hit}, 0);
    chk("seek_run", bus.running, 1);
    tick_slot(0, 1'b1);
    bus.clear      = 1'b1;
    bus.load       = 1'b1;
    bus.load_value = 8'd3;
    cyc();
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    chk("cl_cnt", bus.count, 0);
    chk("cl_state",
        {bus.running, bus.done}, 0);

    // seek onto compare value: no pulse
    bus.load = 1'b1;
    cyc();
    bus.load = 1'b0;
    chk("lcmp_cnt", bus.count, 3);
    chk("lcmp_hit", bus.cmp_hit, 0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    tick_slot(4, 1'b0);

    // async reset mid-run
    cyc();
    #2 reset = 1'b1;
    #1;
    chk("arst_cnt", bus.count, 0);
    chk("arst_flags",
        {26'd0, bus.tick, bus.running, bus.done,
         bus.wrapped, bus.cmp_hit}, 0);
    cyc();
    reset     = 1'b0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("rerun", bus.running, 1);
    tick_slot(1, 1'b0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
